// File: rtl/spi_flash_op_seq_pkg.sv
// Shared definitions for the SPI flash operation sequencer: command-layer
// opcodes, user op encodings, sequencer states and op validity helpers.
package spi_flash_op_seq_pkg;

  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_SE   = 8'hD8;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_RDID = 8'h9F;

  localparam logic [8:0] RDID_BYTES = 9'd3;
  localparam logic [8:0] PAGE_BYTES = 9'd256;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_PROGRAM = 2'd1,
    OP_ERASE   = 2'd2,
    OP_RDID    = 2'd3
  } op_code_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_WREN  = 3'd2,
    ST_MAIN  = 3'd3,
    ST_POLL  = 3'd4,
    ST_GAP   = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_t;

  // READ/PROGRAM need 1..256 bytes; PROGRAM must also stay inside one page.
  // ERASE and RDID carry no byte count, so they are always acceptable.
  function automatic logic op_is_valid(op_code_t code, logic [23:0] op_addr,
                                       logic [8:0] op_size);
    logic       size_ok;
    logic [9:0] end_off;
    size_ok = (op_size != 9'd0) && (op_size <= PAGE_BYTES);
    end_off = {2'b00, op_addr[7:0]} + {1'b0, op_size};
    case (code)
      OP_READ:    op_is_valid = size_ok;
      OP_PROGRAM: op_is_valid = size_ok && (end_off <= {1'b0, PAGE_BYTES});
      default:    op_is_valid = 1'b1;
    endcase
  endfunction

  // Ops that modify the array need a write-enable and status polling.
  function automatic logic op_needs_wren(op_code_t code);
    op_needs_wren = (code == OP_PROGRAM) || (code == OP_ERASE);
  endfunction

  function automatic logic [7:0] main_opcode(op_code_t code);
    case (code)
      OP_READ:    main_opcode = CMD_READ;
      OP_PROGRAM: main_opcode = CMD_PP;
      OP_ERASE:   main_opcode = CMD_SE;
      default:    main_opcode = CMD_RDID;
    endcase
  endfunction

  function automatic logic is_issue_state(state_t s);
    is_issue_state = (s == ST_WREN) || (s == ST_MAIN) || (s == ST_POLL);
  endfunction

endpackage

// File: rtl/spi_flash_op_seq.sv
// SPI flash operation sequencer. Expands a user op into the ordered
// command-layer transactions WREN -> main command -> RDSR polling, and is the
// only driver of the command layer's request port.
//
// Command handshake: cmd/addr/size are valid whenever cmd_valid is high and do
// not change until the command layer pulses cmd_ack. A cmd_ack counts only
// while cmd_valid is high; cmd_valid then drops for at least one cycle, so the
// command layer always sees a fresh rising request per command and never more
// than one outstanding command.
module spi_flash_op_seq
  import spi_flash_op_seq_pkg::*;
#(
  parameter int unsigned POLL_GAP = 100,
  parameter int unsigned POLL_MAX = 65535
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        op_req,
  input  logic [1:0]  op_code,
  input  logic [23:0] op_addr,
  input  logic [8:0]  op_size,
  output logic        op_ack,
  output logic        op_done,
  output logic        op_err,
  output logic        busy,
  output logic [7:0]  flash_sr,
  output logic [7:0]  cmd,
  output logic        cmd_valid,
  input  logic        cmd_ack,
  output logic [23:0] addr,
  output logic [8:0]  size,
  input  logic        rd_valid,
  input  logic [7:0]  rd_data,
  output logic [2:0]  dbg_state
);

  localparam logic [15:0] GAP_LAST  = 16'(POLL_GAP - 1);
  localparam logic [15:0] POLL_LAST = 16'(POLL_MAX);

  state_t      state_q, state_d;
  op_code_t    code_q;
  logic [23:0] addr_q;
  logic [8:0]  size_q;
  logic [15:0] poll_cnt_q;
  logic [15:0] gap_cnt_q;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  flash_sr_q;
  logic        cmd_done;
  logic [7:0]  sr_now;
  logic [15:0] poll_next;

  // An acknowledge only finishes a command that is actually outstanding.
  assign cmd_done  = cmd_valid_q && cmd_ack;
  // A status byte arriving together with the ack still decides the poll.
  assign sr_now    = (state_q == ST_POLL && rd_valid) ? rd_data : flash_sr_q;
  assign poll_next = poll_cnt_q + 16'd1;

  // State register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state selection and request-valid generation.
  always_comb begin
    state_d     = state_q;
    cmd_valid_d = 1'b0;
    case (state_q)
      ST_IDLE:  if (op_req) state_d = ST_CHECK;
      ST_CHECK: begin
        if (!op_is_valid(code_q, addr_q, size_q)) state_d = ST_ERR;
        else if (op_needs_wren(code_q))           state_d = ST_WREN;
        else                                      state_d = ST_MAIN;
      end
      ST_WREN:  if (cmd_done) state_d = ST_MAIN;
      ST_MAIN: begin
        if (cmd_done) state_d = op_needs_wren(code_q) ? ST_POLL : ST_DONE;
      end
      ST_POLL: begin
        if (cmd_done) begin
          if (!sr_now[0])               state_d = ST_DONE;
          else if (poll_next == POLL_LAST) state_d = ST_ERR;
          else                          state_d = ST_GAP;
        end
      end
      ST_GAP:   if (gap_cnt_q == GAP_LAST) state_d = ST_POLL;
      ST_DONE:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (is_issue_state(state_d) && !cmd_done) cmd_valid_d = 1'b1;
  end

  // Request valid register; cleared for a cycle after every accepted ack.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) cmd_valid_q <= 1'b0;
    else     cmd_valid_q <= cmd_valid_d;
  end

  // Latch the user op at acceptance; held for the whole op.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      code_q <= OP_READ;
      addr_q <= '0;
      size_q <= '0;
    end else if (state_q == ST_IDLE && op_req) begin
      code_q <= op_code_t'(op_code);
      addr_q <= op_addr;
      size_q <= op_size;
    end
  end

  // Count RDSR polls of the current op; restarts at every accepted op.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                                poll_cnt_q <= '0;
    else if (state_q == ST_CHECK)           poll_cnt_q <= '0;
    else if (state_q == ST_POLL && cmd_done) poll_cnt_q <= poll_next;
  end

  // Idle-cycle timer between consecutive polls.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                    gap_cnt_q <= '0;
    else if (state_q == ST_GAP) gap_cnt_q <= gap_cnt_q + 16'd1;
    else                        gap_cnt_q <= '0;
  end

  // Capture the status byte returned by RDSR; kept between ops.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                                flash_sr_q <= '0;
    else if (state_q == ST_POLL && rd_valid) flash_sr_q <= rd_data;
  end

  // Command fields derived from the current state and the latched op.
  always_comb begin
    cmd  = 8'h00;
    addr = 24'h0;
    size = 9'd0;
    case (state_q)
      ST_WREN: cmd = CMD_WREN;
      ST_MAIN: begin
        cmd = main_opcode(code_q);
        case (code_q)
          OP_READ, OP_PROGRAM: begin
            addr = addr_q;
            size = size_q;
          end
          OP_ERASE: addr = addr_q;
          default:  size = RDID_BYTES;
        endcase
      end
      ST_POLL: begin
        cmd  = CMD_RDSR;
        size = 9'd1;
      end
      default: ;
    endcase
  end

  assign cmd_valid = cmd_valid_q;
  assign op_ack    = (state_q == ST_CHECK);
  assign op_done   = (state_q == ST_DONE);
  assign op_err    = (state_q == ST_ERR);
  assign busy      = (state_q != ST_IDLE);
  assign flash_sr  = flash_sr_q;
  assign dbg_state = state_q;

endmodule
